// File: rtl/fpu_wb_master.sv
// Wishbone classic initiator for the FPU register block: writes operands, rounding
// mode and op-select, polls status until done, then returns result and exceptions.
module fpu_wb_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [7:0]  OPA_OFF     = 8'h00,
  parameter logic [7:0]  OPB_OFF     = 8'h04,
  parameter logic [7:0]  OPC_OFF     = 8'h08,
  parameter logic [7:0]  FRM_OFF     = 8'h0C,
  parameter logic [7:0]  OP_OFF      = 8'h10,
  parameter logic [7:0]  RES_OFF     = 8'h14,
  parameter logic [7:0]  STAT_OFF    = 8'h18,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned POLL_MAX    = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_opa,
  input  logic [31:0] cmd_opb,
  input  logic [31:0] cmd_opc,
  input  logic [2:0]  cmd_frm,
  input  logic [12:0] cmd_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_exc,
  output logic [1:0]  resp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_C, WR_FRM, WR_OP, RD_STAT, RD_RES, RESP
  } state_t;

  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);

  state_t            state, state_n;
  logic              gap, gap_n;
  logic [31:0]       opa_q, opb_q, opc_q;
  logic [2:0]        frm_q;
  logic [12:0]       op_q;
  logic [ACK_W-1:0]  ack_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic [4:0]        stat_exc;
  logic [7:0]        offset;
  logic [31:0]       wdata;
  logic              is_write, in_beat, active, accept, beat_done, timeout, poll_more;

  assign cmd_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign in_beat    = (state != IDLE) && (state != RESP);
  // gap marks the one idle bus cycle between consecutive beats
  assign active     = in_beat & ~gap;
  assign beat_done  = active & wbm_ack_i;
  assign timeout    = active & ~wbm_ack_i & (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
  assign poll_more  = (32'(poll_cnt) + 32'd1) < 32'(POLL_MAX);

  assign wbm_cyc_o = active;
  assign wbm_stb_o = active;
  assign wbm_we_o  = active & is_write;
  assign wbm_sel_o = active ? 4'hF : 4'h0;
  assign wbm_adr_o = active ? (BASE_ADDR + {24'h0, offset}) : 32'h0;
  assign wbm_dat_o = (active & is_write) ? wdata : 32'h0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_n  = state;
    gap_n    = gap;
    offset   = 8'h00;
    wdata    = 32'h0;
    is_write = 1'b0;

    case (state)
      WR_A:    begin offset = OPA_OFF; wdata = opa_q;           is_write = 1'b1; end
      WR_B:    begin offset = OPB_OFF; wdata = opb_q;           is_write = 1'b1; end
      WR_C:    begin offset = OPC_OFF; wdata = opc_q;           is_write = 1'b1; end
      WR_FRM:  begin offset = FRM_OFF; wdata = {29'h0, frm_q};  is_write = 1'b1; end
      WR_OP:   begin offset = OP_OFF;  wdata = {19'h0, op_q};   is_write = 1'b1; end
      RD_STAT: offset = STAT_OFF;
      RD_RES:  offset = RES_OFF;
      default: ;
    endcase

    case (state)
      IDLE: if (cmd_valid) begin
        state_n = WR_A;
        gap_n   = 1'b0;
      end
      RESP: if (resp_ready) state_n = IDLE;
      default: begin
        if (gap) begin
          gap_n = 1'b0;
        end else if (beat_done) begin
          gap_n = 1'b1;
          case (state)
            WR_A:    state_n = WR_B;
            WR_B:    state_n = op_q[10] ? WR_C : WR_FRM;
            WR_C:    state_n = WR_FRM;
            WR_FRM:  state_n = WR_OP;
            WR_OP:   state_n = RD_STAT;
            RD_STAT: state_n = wbm_dat_i[0] ? RD_RES : (poll_more ? RD_STAT : RESP);
            default: state_n = RESP;
          endcase
        end else if (timeout) begin
          state_n = RESP;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (wb_rst_i) begin
      state <= IDLE;
      gap   <= 1'b0;
    end else begin
      state <= state_n;
      gap   <= gap_n;
    end
  end

  // NOTE: the command latch has no reset; it is only read in states entered after a fresh accept.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      opa_q <= cmd_opa;
      opb_q <= cmd_opb;
      opc_q <= cmd_opc;
      frm_q <= cmd_frm;
      op_q  <= cmd_op;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_cnt     <= '0;
      poll_cnt    <= '0;
      stat_exc    <= '0;
      resp_result <= '0;
      resp_exc    <= '0;
      resp_err    <= '0;
    end else begin
      if (accept) begin
        ack_cnt  <= '0;
        poll_cnt <= '0;
      end else if (in_beat && gap) begin
        ack_cnt <= '0;
      end else if (active && !wbm_ack_i) begin
        ack_cnt <= ack_cnt + ACK_W'(1);
      end

      if (beat_done && state == RD_STAT) begin
        poll_cnt <= poll_cnt + POLL_W'(1);
        if (wbm_dat_i[0]) begin
          stat_exc <= wbm_dat_i[5:1];
        end else if (!poll_more) begin
          resp_result <= '0;
          resp_exc    <= '0;
          resp_err    <= 2'b10;
        end
      end

      if (beat_done && state == RD_RES) begin
        resp_result <= wbm_dat_i;
        resp_exc    <= stat_exc;
        resp_err    <= 2'b00;
      end

      if (timeout) begin
        resp_result <= '0;
        resp_exc    <= '0;
        resp_err    <= 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_fpu_wb_master.sv
// Self-checking bench for fpu_wb_master: a Wishbone slave model plus a
// transaction-level model of the expected beats, response and latency.
module tb_fpu_wb_master;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] A_OP    = BASE + 32'h10;
  localparam logic [31:0] A_RES   = BASE + 32'h14;
  localparam logic [31:0] A_STAT  = BASE + 32'h18;
  localparam int          TIMEOUT = 255;
  localparam int          POLLS   = 64;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_opa, cmd_opb, cmd_opc;
  logic [2:0]  cmd_frm;
  logic [12:0] cmd_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_exc;
  logic [1:0]  resp_err;
  logic        busy;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  fpu_wb_master dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_opc(cmd_opc),
    .cmd_frm(cmd_frm), .cmd_op(cmd_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_exc(resp_exc), .resp_err(resp_err),
    .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave behaviour knobs
  int          wait_st = 0;
  bit          never_ack_en = 0;
  logic [31:0] never_ack_adr = '0;
  bit          gap_ack = 0;
  logic [31:0] stat_q[$];
  logic [31:0] stat_last = '0;
  logic [31:0] res_val = '0;

  // Model expectations
  beat_t       exp_beats[$];
  logic [31:0] exp_result;
  logic [4:0]  exp_exc;
  logic [1:0]  exp_err;
  int          exp_lat;
  int          exp_polls;

  // Monitor bookkeeping
  bit    prev_stb = 0;
  int    stb_cycles = 0;
  int    stat_reads = 0;
  int    last_stb_cycles = 0;
  beat_t cur;

  function automatic beat_t mk(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    beat_t b;
    b.adr = adr;
    b.we  = we;
    b.dat = dat;
    return b;
  endfunction

  // Expected bus transactions, response and accept-to-response latency for one command.
  task automatic setup_model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [2:0] frm, input logic [12:0] op);
    beat_t       list[$];
    logic [31:0] s;
    bit          done;
    int          total;
    done = 0;
    list.push_back(mk(BASE + 32'h00, 1'b1, a));
    list.push_back(mk(BASE + 32'h04, 1'b1, b));
    if (op[10]) list.push_back(mk(BASE + 32'h08, 1'b1, c));
    list.push_back(mk(BASE + 32'h0C, 1'b1, {29'h0, frm}));
    list.push_back(mk(A_OP, 1'b1, {19'h0, op}));
    exp_result = '0;
    exp_exc    = '0;
    exp_err    = 2'b10;
    for (int i = 0; i < POLLS; i++) begin
      s = (i < stat_q.size()) ? stat_q[i] : stat_last;
      list.push_back(mk(A_STAT, 1'b0, 32'h0));
      if (s[0]) begin
        done    = 1;
        exp_exc = s[5:1];
        break;
      end
    end
    if (done) begin
      list.push_back(mk(A_RES, 1'b0, 32'h0));
      exp_result = res_val;
      exp_err    = 2'b00;
    end
    exp_beats.delete();
    total = 0;
    for (int i = 0; i < list.size(); i++) begin
      exp_beats.push_back(list[i]);
      if (never_ack_en && list[i].adr == never_ack_adr) begin
        total     += TIMEOUT + 1;
        exp_result = '0;
        exp_exc    = '0;
        exp_err    = 2'b01;
        break;
      end
      total += wait_st + 2;
    end
    exp_lat   = total;
    exp_polls = 0;
    for (int i = 0; i < exp_beats.size(); i++)
      if (exp_beats[i].adr == A_STAT) exp_polls++;
  endtask

  // Compare process and Wishbone slave, all on the falling edge.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      check("cyc_eq_stb", wbm_cyc_o, wbm_stb_o);
      if (wbm_cyc_o && wbm_stb_o) begin
        if (!prev_stb) begin
          check("beat_expected", exp_beats.size() > 0, 1);
          if (exp_beats.size() > 0) cur = exp_beats.pop_front();
          else cur = mk(32'hFFFF_FFFF, 1'b0, 32'h0);
          check("beat_adr", wbm_adr_o, cur.adr);
          check("beat_we", wbm_we_o, cur.we);
          check("beat_dat", wbm_dat_o, cur.dat);
          check("beat_sel", wbm_sel_o, 4'hF);
          if (wbm_adr_o == A_STAT) stat_reads++;
          stb_cycles = 1;
        end else begin
          stb_cycles++;
          check("beat_adr_hold", wbm_adr_o, cur.adr);
          check("beat_dat_hold", wbm_dat_o, cur.dat);
        end
        if (never_ack_en && wbm_adr_o == never_ack_adr) begin
          wbm_ack_i = 1'b0;
        end else if (stb_cycles > wait_st) begin
          wbm_ack_i = 1'b1;
          if (wbm_adr_o == A_STAT) begin
            if (stat_q.size() > 0) wbm_dat_i = stat_q.pop_front();
            else wbm_dat_i = stat_last;
          end else if (wbm_adr_o == A_RES) begin
            wbm_dat_i = res_val;
          end else begin
            wbm_dat_i = 32'h0;
          end
        end else begin
          wbm_ack_i = 1'b0;
        end
        prev_stb = !wbm_ack_i;
      end else begin
        if (prev_stb) last_stb_cycles = stb_cycles;
        prev_stb  = 0;
        wbm_ack_i = gap_ack;
        wbm_dat_i = gap_ack ? 32'hFFFF_FFFF : 32'h0;
      end
      if (resp_valid) begin
        check("resp_result", resp_result, exp_result);
        check("resp_exc", resp_exc, exp_exc);
        check("resp_err", resp_err, exp_err);
        check("resp_cmd_ready", cmd_ready, 0);
      end
    end
  end

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] frm, input logic [12:0] op, input int hold,
                         output int lat, output logic [31:0] res,
                         output logic [4:0] exc, output logic [1:0] err);
    setup_model(a, b, c, frm, op);
    stat_reads = 0;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_opa = a; cmd_opb = b; cmd_opc = c; cmd_frm = frm; cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_opa = ~a; cmd_opb = ~b; cmd_opc = ~c; cmd_frm = ~frm; cmd_op = ~op;
    check("accept_ready_low", cmd_ready, 0);
    check("accept_busy", busy, 1);
    lat = 1;
    while (!resp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", lat, exp_lat);
    res = resp_result;
    exc = resp_exc;
    err = resp_err;
    repeat (hold) @(negedge clk);
    check("resp_held", resp_valid, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("handshake_done", resp_valid, 0);
    check("ready_after_resp", cmd_ready, 1);
    check("idle_not_busy", busy, 0);
    check("beats_consumed", exp_beats.size(), 0);
    check("stat_reads", stat_reads, exp_polls);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n;
    logic [31:0] res;
    logic [4:0]  exc;
    logic [1:0]  err;

    rst = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b0;
    cmd_opa = '0; cmd_opb = '0; cmd_opc = '0; cmd_frm = '0; cmd_op = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_result", resp_result, 0);
    check("rst_exc", resp_exc, 0);
    check("rst_err", resp_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Add, zero-wait ack
    stat_q = '{32'h1}; stat_last = '0; res_val = 32'h4040_0000;
    run_cmd(32'h3F80_0000, 32'h4000_0000, 32'h0, 3'b001, 13'h0101, 0, lat, res, exc, err);
    check("add_lat_lit", lat, 12);
    check("add_result_lit", res, 32'h4040_0000);
    check("add_err_lit", err, 2'b00);
    check("add_polls_lit", stat_reads, 1);

    // FMA carries the OPC beat
    stat_q = '{32'h1}; res_val = 32'h4100_0000;
    run_cmd(32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 3'b000, 13'h0400, 2, lat, res, exc, err);
    check("fma_lat_lit", lat, 14);
    check("fma_result_lit", res, 32'h4100_0000);

    // One wait state per beat, ack held high in gaps and idle
    wait_st = 1; gap_ack = 1;
    stat_q = '{32'h1}; res_val = 32'h1234_5678;
    run_cmd(32'h1111_1111, 32'h2222_2222, 32'h0, 3'b100, 13'h0002, 0, lat, res, exc, err);
    check("wait_lat_lit", lat, 18);
    check("wait_result_lit", res, 32'h1234_5678);
    wait_st = 0; gap_ack = 0;

    // Slow status: three not-done polls, then done with exceptions
    stat_q = '{32'h0, 32'h0, 32'h0, 32'h5}; res_val = 32'h3F00_0000;
    run_cmd(32'h3F80_0000, 32'hBF80_0000, 32'h0, 3'b010, 13'h0101, 0, lat, res, exc, err);
    check("slow_polls_lit", stat_reads, 4);
    check("slow_exc_lit", exc, 5'b00010);
    check("slow_err_lit", err, 2'b00);
    check("slow_lat_lit", lat, 18);

    // Ack timeout on WR_B
    never_ack_en = 1; never_ack_adr = BASE + 32'h04; stat_q = '{32'h1}; res_val = 32'hAAAA_5555;
    run_cmd(32'h5, 32'h6, 32'h0, 3'b000, 13'h0101, 0, lat, res, exc, err);
    check("tmo_stb_cycles_lit", last_stb_cycles, 255);
    check("tmo_err_lit", err, 2'b01);
    check("tmo_result_lit", res, 32'h0);
    check("tmo_lat_lit", lat, 258);
    never_ack_en = 0;

    // Poll exhausted with back-pressure
    stat_q.delete(); stat_last = 32'h0;
    run_cmd(32'h7, 32'h8, 32'h0, 3'b011, 13'h0101, 10, lat, res, exc, err);
    check("exh_polls_lit", stat_reads, 64);
    check("exh_err_lit", err, 2'b10);
    check("exh_lat_lit", lat, 136);

    // Reset while WR_OP has stb high
    wait_st = 2; stat_q = '{32'h1}; res_val = 32'h0;
    setup_model(32'h9, 32'hA, 32'h0, 3'b000, 13'h0101);
    cmd_valid = 1'b1; cmd_opa = 32'h9; cmd_opb = 32'hA; cmd_opc = 32'h0; cmd_frm = 3'b000;
    cmd_op = 13'h0101;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(wbm_stb_o && wbm_adr_o == A_OP) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_wr_op_reached", wbm_stb_o && wbm_adr_o == A_OP, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cyc", wbm_cyc_o, 0);
    check("midrst_stb", wbm_stb_o, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_resp_valid", resp_valid, 0);
    exp_beats.delete();
    stat_q.delete();
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_resp", resp_valid, 0);
    end

    // Recovery after reset
    wait_st = 0; stat_q = '{32'h3}; res_val = 32'hC0DE_0001;
    run_cmd(32'hB, 32'hC, 32'h0, 3'b001, 13'h0101, 1, lat, res, exc, err);
    check("recov_lat_lit", lat, 12);
    check("recov_exc_lit", exc, 5'b00001);
    check("recov_result_lit", res, 32'hC0DE_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
